// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame buffer: raster writer fills the back bank, scan-out reads the
// front bank with integer pixel/line replication; banks swap only on disp_sof.
module frame_buffer_ctrl #(
    parameter int WIDTH  = 200,
    parameter int HEIGHT = 150,
    parameter int BPP    = 1,
    parameter int SCALE  = 4,
    parameter int ADDRW  = $clog2(WIDTH * HEIGHT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [BPP-1:0] wr_data,
    input  logic           wr_sof,
    output logic           frame_done,
    input  logic           disp_sof,
    input  logic           disp_active,
    output logic [BPP-1:0] pix_out,
    output logic           pix_valid,
    output logic [7:0]     drop_cnt,
    output logic           sof_err
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int XW    = $clog2(WIDTH > 1 ? WIDTH : 2);
    localparam int YW    = $clog2(HEIGHT > 1 ? HEIGHT : 2);
    localparam int SW    = $clog2(SCALE > 1 ? SCALE : 2);
    localparam int LBW   = ADDRW + 1;
    localparam int DEPTH = 2 ** (ADDRW + 1);

    localparam logic [XW-1:0]    X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [SW-1:0]    S_LAST  = SW'(SCALE - 1);
    localparam logic [ADDRW-1:0] A_LAST  = ADDRW'(NPIX - 1);
    localparam logic [LBW-1:0]   LB_STEP = LBW'(WIDTH);
    localparam logic [LBW-1:0]   LB_END  = LBW'(NPIX);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Line bases run one row past the frame; reads never go beyond the last pixel.
    function automatic logic [ADDRW-1:0] clamp_addr(input logic [LBW-1:0] a);
        return (a >= LB_END) ? A_LAST : a[ADDRW-1:0];
    endfunction

    logic [XW-1:0]    wr_x_q, wr_x_d;
    logic [YW-1:0]    wr_y_q, wr_y_d;
    logic [ADDRW-1:0] wr_addr_q, wr_addr_d, wr_offset;
    logic             back_full_q, back_full_d;
    logic             front_q, front_d;
    logic             frame_done_q, frame_done_d;
    logic             sof_err_q, sof_err_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [SW-1:0]    sx_sub_q, sx_sub_d, sy_sub_q, sy_sub_d;
    logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
    logic [LBW-1:0]   line_base_q, line_base_d, lb_sum;
    logic             act_p1_q;
    logic [BPP-1:0]   rd_data_p1;
    logic [BPP-1:0]   pix_out_q, pix_out_d;
    logic             pix_valid_q;
    logic             accept;

    logic [BPP-1:0]   mem [DEPTH];

    always_comb begin
        accept       = wr_valid & ~back_full_q;
        wr_x_d       = wr_x_q;
        wr_y_d       = wr_y_q;
        wr_addr_d    = wr_addr_q;
        wr_offset    = wr_addr_q;
        back_full_d  = back_full_q;
        front_d      = front_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        sx_sub_d     = sx_sub_q;
        sy_sub_d     = sy_sub_q;
        rd_addr_d    = rd_addr_q;
        line_base_d  = line_base_q;
        lb_sum       = line_base_q + LB_STEP;
        pix_out_d    = act_p1_q ? rd_data_p1 : '0;

        if (accept) begin
            if (wr_sof) begin
                // wr_sof re-anchors the frame: this pixel is (0,0), next is (1,0).
                wr_offset = '0;
                sof_err_d = (wr_x_q != '0) || (wr_y_q != '0);
                wr_x_d    = XW'(1);
                wr_y_d    = '0;
                wr_addr_d = ADDRW'(1);
            end else if (wr_x_q == X_LAST) begin
                wr_x_d = '0;
                if (wr_y_q == Y_LAST) begin
                    wr_y_d       = '0;
                    wr_addr_d    = '0;
                    back_full_d  = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    wr_y_d    = wr_y_q + 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end else begin
                wr_x_d    = wr_x_q + 1'b1;
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        // Swap decision uses the registered back_full, so a frame finishing now waits.
        if (disp_sof) begin
            if (back_full_q) begin
                front_d     = ~front_q;
                back_full_d = 1'b0;
            end else begin
                drop_cnt_d = sat_inc8(drop_cnt_q);
            end
        end

        if (disp_sof) begin
            sx_sub_d    = '0;
            sy_sub_d    = '0;
            rd_addr_d   = '0;
            line_base_d = '0;
        end else if (disp_active) begin
            if (sx_sub_q == S_LAST) begin
                sx_sub_d = '0;
                if (rd_addr_q != A_LAST) rd_addr_d = rd_addr_q + 1'b1;
            end else begin
                sx_sub_d = sx_sub_q + 1'b1;
            end
        end else if (act_p1_q) begin
            sx_sub_d = '0;
            if (sy_sub_q == S_LAST) begin
                sy_sub_d    = '0;
                line_base_d = (lb_sum > LB_END) ? LB_END : lb_sum;
                rd_addr_d   = clamp_addr(lb_sum);
            end else begin
                sy_sub_d  = sy_sub_q + 1'b1;
                rd_addr_d = clamp_addr(line_base_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            wr_addr_q    <= '0;
            back_full_q  <= 1'b0;
            front_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            drop_cnt_q   <= '0;
            sx_sub_q     <= '0;
            sy_sub_q     <= '0;
            rd_addr_q    <= '0;
            line_base_q  <= '0;
            act_p1_q     <= 1'b0;
            pix_out_q    <= '0;
            pix_valid_q  <= 1'b0;
        end else begin
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            wr_addr_q    <= wr_addr_d;
            back_full_q  <= back_full_d;
            front_q      <= front_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            drop_cnt_q   <= drop_cnt_d;
            sx_sub_q     <= sx_sub_d;
            sy_sub_q     <= sy_sub_d;
            rd_addr_q    <= rd_addr_d;
            line_base_q  <= line_base_d;
            act_p1_q     <= disp_active;
            pix_out_q    <= pix_out_d;
            pix_valid_q  <= act_p1_q;
        end
    end

    // Stage p1: synchronous RAM write to the back bank and read from the front bank.
    always_ff @(posedge clk) begin
        if (accept) mem[{~front_q, wr_offset}] <= wr_data;
        rd_data_p1 <= mem[{front_q, rd_addr_q}];
    end

    assign wr_ready   = ~back_full_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;
    assign drop_cnt   = drop_cnt_q;
    assign pix_out    = pix_out_q;
    assign pix_valid  = pix_valid_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl: a small 4x3 instance with randomized
// traffic and a full-size 200x150 SCALE=1 instance scanned end to end.
module tb_frame_buffer_ctrl;

    localparam int W = 4, H = 3, BPP = 2, S = 2, N = W * H;
    localparam int BW = 200, BH = 150, BN = BW * BH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b1;
    logic           wr_valid = 1'b0, wr_sof = 1'b0, disp_sof = 1'b0, disp_active = 1'b0;
    logic [BPP-1:0] wr_data = '0;
    logic           wr_ready, frame_done, pix_valid, sof_err;
    logic [BPP-1:0] pix_out;
    logic [7:0]     drop_cnt;

    logic           b_rst_n = 1'b1;
    logic           b_wr_valid = 1'b0, b_wr_sof = 1'b0, b_disp_sof = 1'b0, b_disp_active = 1'b0;
    logic [0:0]     b_wr_data = '0;
    logic           b_wr_ready, b_frame_done, b_pix_valid, b_sof_err;
    logic [0:0]     b_pix_out;
    logic [7:0]     b_drop_cnt;

    frame_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .BPP(BPP), .SCALE(S)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_sof(wr_sof), .frame_done(frame_done),
        .disp_sof(disp_sof), .disp_active(disp_active), .pix_out(pix_out),
        .pix_valid(pix_valid), .drop_cnt(drop_cnt), .sof_err(sof_err)
    );

    frame_buffer_ctrl #(.WIDTH(BW), .HEIGHT(BH), .BPP(1), .SCALE(1)) dut_big (
        .clk(clk), .rst_n(b_rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_data(b_wr_data), .wr_sof(b_wr_sof), .frame_done(b_frame_done),
        .disp_sof(b_disp_sof), .disp_active(b_disp_active), .pix_out(b_pix_out),
        .pix_valid(b_pix_valid), .drop_cnt(b_drop_cnt), .sof_err(b_sof_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: two banks of pixels, which one is shown, and the raster position.
    typedef struct { int cyc; int val; } exp_t;
    int   m_mem [2][N];
    int   m_front, m_full, m_wpos, m_drop, m_line, m_col;
    bit   m_prev_act;
    exp_t pix_q[$];
    int   fd_q[$];
    int   se_q[$];

    task automatic model_reset();
        m_front = 0; m_full = 0; m_wpos = 0; m_drop = 0;
        m_line = 0; m_col = 0; m_prev_act = 0;
        pix_q.delete(); fd_q.delete(); se_q.delete();
    endtask

    function automatic int exp_pix(input int line, input int col);
        int a;
        a = (line / S) * W + col / S;
        if (a > N - 1) a = N - 1;
        return m_mem[m_front][a];
    endfunction

    // One clock of stimulus; the model advances using the state before this edge.
    task automatic step(input bit v, input int d, input bit sof, input bit dsof, input bit dact);
        exp_t e;
        bit acc;
        wr_valid = v; wr_data = BPP'(d); wr_sof = sof; disp_sof = dsof; disp_active = dact;
        check("wr_ready", int'(wr_ready), (m_full == 0) ? 1 : 0);
        acc = v && (m_full == 0);
        if (dsof) begin
            if (m_full != 0) begin m_front = 1 - m_front; m_full = 0; end
            else if (m_drop < 255) m_drop++;
            m_line = 0; m_col = 0;
        end else if (dact) begin
            e.cyc = cyc + 2; e.val = exp_pix(m_line, m_col);
            pix_q.push_back(e);
            m_col++;
        end else if (m_prev_act) begin
            m_line++; m_col = 0;
        end
        m_prev_act = dact;
        if (acc) begin
            if (sof) begin
                if (m_wpos != 0) se_q.push_back(cyc + 1);
                m_mem[1 - m_front][0] = d;
                m_wpos = 1;
            end else begin
                m_mem[1 - m_front][m_wpos] = d;
                m_wpos++;
                if (m_wpos == N) begin m_wpos = 0; m_full = 1; fd_q.push_back(cyc + 1); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic write_frame(input int n, input bit gaps, input bit rnd);
        int done = 0, guard = 0;
        bit v;
        int d;
        while (done < n && guard < 2000) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = rnd ? int'($urandom_range(0, 3)) : (m_wpos % 4);
            if (v && m_full == 0) done++;
            step(v, d, 0, 0, 0);
            guard++;
        end
        check("write_frame_accepts", done, n);
    endtask

    task automatic scan_lines(input int nl, input int act, input bit bg);
        for (int l = 0; l < nl; l++) begin
            for (int c = 0; c < act; c++) step(bg, int'($urandom_range(0, 3)), 0, 0, 1);
            for (int c = 0; c < 3; c++) step(bg, int'($urandom_range(0, 3)), 0, 0, 0);
        end
    endtask

    task automatic show(input int nl, input int act, input bit bg);
        step(0, 0, 0, 1, 0);
        idle(2);
        scan_lines(nl, act, bg);
        check("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, int'(wr_ready), 1);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_pix_out"}, int'(pix_out), 0);
        check({tag, "_pix_valid"}, int'(pix_valid), 0);
        check({tag, "_drop_cnt"}, int'(drop_cnt), 0);
        check({tag, "_sof_err"}, int'(sof_err), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output event.
    always @(negedge clk) begin : mon
        exp_t e;
        if (pix_valid) begin
            if (pix_q.size() == 0) check("pix_unexpected", 1, 0);
            else begin
                e = pix_q.pop_front();
                check("pix_latency", cyc, e.cyc);
                check("pix_value", int'(pix_out), e.val);
            end
        end else begin
            check("pix_idle_zero", int'(pix_out), 0);
            if (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
                check("pix_missing", 0, 1);
                void'(pix_q.pop_front());
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) check("frame_done_spurious", 1, 0);
            else check("frame_done_cycle", cyc, fd_q.pop_front());
        end else if (fd_q.size() > 0 && fd_q[0] < cyc) begin
            check("frame_done_missing", 0, 1);
            void'(fd_q.pop_front());
        end
        if (sof_err) begin
            if (se_q.size() == 0) check("sof_err_spurious", 1, 0);
            else check("sof_err_cycle", cyc, se_q.pop_front());
        end else if (se_q.size() > 0 && se_q[0] < cyc) begin
            check("sof_err_missing", 0, 1);
            void'(se_q.pop_front());
        end
    end

    task automatic small_seq();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // Known 0..3 pattern, shown once with 8-cycle lines.
        write_frame(N, 0, 0);
        idle(2);
        show(6, 8, 0);

        // No new frame: three drops, same image each time.
        for (int k = 0; k < 3; k++) show(6, 8, 0);
        check("drop_after_three", int'(drop_cnt), 3);

        // Random frame with gaps, stalled writes while full, wide/tall scan.
        write_frame(N, 1, 1);
        for (int k = 0; k < 4; k++) step(1, int'($urandom_range(0, 3)), 0, 0, 0);
        show(7, 10, 0);
        show(6, 8, 1);
        show(6, 8, 0);

        // Last pixel accepted in the disp_sof cycle: no swap this frame.
        write_frame(N - 1, 0, 1);
        step(1, int'($urandom_range(0, 3)), 0, 1, 0);
        idle(2);
        scan_lines(6, 8, 0);
        check("drop_same_cycle", int'(drop_cnt), m_drop);
        show(6, 8, 0);

        // wr_sof at pixel 5 re-anchors the frame.
        write_frame(5, 0, 1);
        step(1, int'($urandom_range(0, 3)), 1, 0, 0);
        write_frame(N - 1, 0, 1);
        show(6, 8, 0);

        // Reset in the middle of a write.
        write_frame(5, 0, 1);
        wr_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Partial frame discarded: every disp_sof drops, counter saturates.
        for (int k = 0; k < 260; k++) begin
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 0);
        end
        check("drop_saturate", int'(drop_cnt), 255);

        write_frame(N, 1, 1);
        show(6, 8, 0);
        idle(6);
        check("pix_q_drained", pix_q.size(), 0);
        check("fd_q_drained", fd_q.size(), 0);
        check("se_q_drained", se_q.size(), 0);
    endtask

    bit b_mem [BN];
    bit bq[$];
    int b_fd_cnt = 0;

    always @(negedge clk) begin
        if (b_frame_done) b_fd_cnt++;
        if (b_pix_valid) begin
            if (bq.size() == 0) check("big_pix_unexpected", 1, 0);
            else check("big_pix_value", int'(b_pix_out), int'(bq.pop_front()));
        end
    end

    task automatic big_seq();
        int n, a;
        #2 b_rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        b_rst_n = 1'b1;
        for (int i = 0; i < BN; i++) begin
            b_mem[i] = 1'($urandom_range(0, 1));
            b_wr_valid = 1'b1; b_wr_data = b_mem[i];
            @(posedge clk); #1;
        end
        b_wr_valid = 1'b0;
        @(posedge clk); #1;
        check("big_wr_ready_full", int'(b_wr_ready), 0);
        check("big_frame_done_once", b_fd_cnt, 1);
        b_disp_sof = 1'b1;
        @(posedge clk); #1;
        b_disp_sof = 1'b0;
        @(posedge clk); #1;
        // One extra short line past the end must keep showing the last pixel.
        for (int l = 0; l <= BH; l++) begin
            n = (l < BH) ? BW : 8;
            for (int c = 0; c < n; c++) begin
                a = l * BW + c;
                if (a > BN - 1) a = BN - 1;
                bq.push_back(b_mem[a]);
                b_disp_active = 1'b1;
                @(posedge clk); #1;
            end
            b_disp_active = 1'b0;
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        check("big_pix_drained", bq.size(), 0);
        check("big_drop_cnt", int'(b_drop_cnt), 0);
        check("big_wr_ready_after_swap", int'(b_wr_ready), 1);
    endtask

    initial begin
        fork
            small_seq();
            big_seq();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before cycle 90000");
        $fatal(1, "timeout");
    end

endmodule
